// File: rtl/latch_report_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : latch_report_pkg
// Purpose : Shared definitions for the latch report scheduler: host command
//           byte values, the scheduler FSM state type and the frame payload
//           byte-count helper.
// Ports   : none (package)
// Options : none
// Revision: 1.0 - initial release
// ============================================================================
package latch_report_pkg;

  // Host byte values. ACK1/ACK2 double as the frame tag of each channel.
  localparam logic [7:0] CMD_ACK1  = 8'h00;
  localparam logic [7:0] CMD_ACK2  = 8'h01;
  localparam logic [7:0] CMD_TRIG1 = 8'h02;
  localparam logic [7:0] CMD_TRIG2 = 8'h03;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_CLEAR    = 2'd3
  } state_t;

  // Number of payload bytes needed to carry a value of the given bit width.
  function automatic int nbytes(input int width);
    return (width + 7) / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/latch_report_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : latch_report_scheduler_if
// Purpose : Byte link between the scheduler and the host-side byte FIFO.
// Signals : oTxData/oTxValid  outgoing byte and its valid flag
//           iTxReady          sink accepts the outgoing byte
//           iRxData/iRxValid  incoming host byte and its one-cycle strobe
// Modports: master - scheduler side, slave - FIFO/host side
// Revision: 1.0 - initial release
// ============================================================================
interface latch_report_scheduler_if;
  logic [7:0] oTxData;
  logic       oTxValid;
  logic       iTxReady;
  logic [7:0] iRxData;
  logic       iRxValid;

  modport master (
    output oTxData,
    output oTxValid,
    input  iTxReady,
    input  iRxData,
    input  iRxValid
  );

  modport slave (
    input  oTxData,
    input  oTxValid,
    output iTxReady,
    output iRxData,
    output iRxValid
  );
endinterface
`default_nettype wire

// File: rtl/latch_report_scheduler_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module  : frame_serializer
// Purpose : Emits a tagged frame (tag byte, then pNBYTES payload bytes LSB
//           first) over a valid/ready byte link. The frame image is held so
//           the same frame can be re-sent without re-reading the source.
// Ports   : iCLK, iRSTn       clock, asynchronous active-low reset
//           iStart            load iTag/iData and begin a new frame
//           iRestart          re-send the held frame from its tag byte
//           iTag, iData       tag and zero-extended payload snapshot
//           oTxData, oTxValid registered byte output stage
//           iTxReady          sink accepts the current byte
//           oDone             high in the cycle the last byte transfers
// Revision: 1.0 - initial release
// ============================================================================
module frame_serializer #(
  parameter int pNBYTES = 5
) (
  input  wire logic                   iCLK,
  input  wire logic                   iRSTn,
  input  wire logic                   iStart,
  input  wire logic                   iRestart,
  input  wire logic [7:0]             iTag,
  input  wire logic [pNBYTES*8-1:0]   iData,
  output logic      [7:0]             oTxData,
  output logic                        oTxValid,
  input  wire logic                   iTxReady,
  output logic                        oDone
);

  localparam int FRAME_BITS = (pNBYTES + 1) * 8;
  localparam int IDXW       = $clog2(pNBYTES + 1);

  logic [FRAME_BITS-1:0] r_frame;  // held image {payload, tag} for retransmit
  logic [FRAME_BITS-1:0] r_shift;  // remaining bytes, current byte in [7:0]
  logic [IDXW-1:0]       r_idx;    // index of the byte currently offered
  logic                  r_valid;

  logic w_xfer;
  logic w_last;

  assign w_xfer   = r_valid & iTxReady;
  assign w_last   = (r_idx == IDXW'(pNBYTES));
  assign oTxData  = r_shift[7:0];
  assign oTxValid = r_valid;
  assign oDone    = w_xfer & w_last;

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      r_frame <= '0;
      r_shift <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else if (iStart) begin
      r_frame <= {iData, iTag};
      r_shift <= {iData, iTag};
      r_idx   <= '0;
      r_valid <= 1'b1;
    end else if (iRestart) begin
      r_shift <= r_frame;
      r_idx   <= '0;
      r_valid <= 1'b1;
    end else if (w_xfer) begin
      // Byte accepted: advance, or close the frame after the last byte.
      r_shift <= {8'h00, r_shift[FRAME_BITS-1:8]};
      if (w_last) begin
        r_valid <= 1'b0;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/latch_report_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : latch_report_scheduler
// Purpose : Reports the two latched counter registers to a host over a byte
//           link. Arbitrates the ready flags (round-robin on ties), sends a
//           tagged frame, waits for the host ack, then holds the counter's
//           latch-reset request until the ready flag clears. Host trigger
//           bytes are decoded into one-cycle soft latch pulses in any state.
// Ports   : iCLK, iRSTn                  clock, asynchronous active-low reset
//           iRdy1/iLatch1Val             register 1 ready flag and value
//           iRdy2/iLatch2Val             register 2 ready flag and value
//           oResetLatch1/oResetLatch2    latch-reset requests (level)
//           oSoftLatch1/oSoftLatch2      one-cycle soft latch triggers
//           link (master)                tx/rx byte link
//           oBusy                        FSM not idle
//           oUnexpected                  saturating count of ignored rx bytes
// Options : LATCH_REPORT_ACK_TIMEOUT_EN  retransmit the held frame after
//                                        pACK_TIMEOUT cycles without an ack
// Revision: 1.0 - initial release
// ============================================================================
module latch_report_scheduler
  import latch_report_pkg::*;
#(
  parameter int pWIDTH       = 40,
  parameter int pACK_TIMEOUT = 1000000
) (
  input  wire logic              iCLK,
  input  wire logic              iRSTn,
  input  wire logic              iRdy1,
  input  wire logic [pWIDTH-1:0] iLatch1Val,
  input  wire logic              iRdy2,
  input  wire logic [pWIDTH-1:0] iLatch2Val,
  output logic                   oResetLatch1,
  output logic                   oResetLatch2,
  output logic                   oSoftLatch1,
  output logic                   oSoftLatch2,
  latch_report_scheduler_if.master link,
  output logic                   oBusy,
  output logic [7:0]             oUnexpected
);

  localparam int NB = nbytes(pWIDTH);

  state_t     r_state;
  logic       r_rr_last;   // channel served last: 0 = ch1, 1 = ch2
  logic       r_served;    // channel of the frame in flight
  logic       r_rst1;
  logic       r_rst2;
  logic       r_soft1;
  logic       r_soft2;
  logic [7:0] r_unexp;

  logic            w_grant;
  logic            w_grant_ch2;
  logic [7:0]      w_tag;
  logic [7:0]      w_tag_held;
  logic [NB*8-1:0] w_snap;
  logic            w_done;
  logic            w_restart;
  logic            w_rx_ack;
  logic            w_rx_trig1;
  logic            w_rx_trig2;
  logic            w_rx_unexp;
  logic            w_served_rdy;

  // ch2 wins when it is the only one ready, or on a tie when ch1 went last.
  assign w_grant_ch2  = iRdy2 & (~iRdy1 | ~r_rr_last);
  assign w_grant      = (r_state == ST_IDLE) & (iRdy1 | iRdy2);
  assign w_tag        = w_grant_ch2 ? CMD_ACK2 : CMD_ACK1;
  assign w_tag_held   = r_served ? CMD_ACK2 : CMD_ACK1;
  assign w_served_rdy = r_served ? iRdy2 : iRdy1;

  always_comb begin
    w_snap = '0;
    if (w_grant_ch2) begin
      w_snap[pWIDTH-1:0] = iLatch2Val;
    end else begin
      w_snap[pWIDTH-1:0] = iLatch1Val;
    end
  end

  // Rx decode. Only the tag of the frame in flight counts as an ack, and
  // only while waiting for it; every other non-trigger byte is counted.
  assign w_rx_ack   = link.iRxValid & (r_state == ST_WAIT_ACK) & (link.iRxData == w_tag_held);
  assign w_rx_trig1 = link.iRxValid & (link.iRxData == CMD_TRIG1);
  assign w_rx_trig2 = link.iRxValid & (link.iRxData == CMD_TRIG2);
  assign w_rx_unexp = link.iRxValid & ~w_rx_ack & ~w_rx_trig1 & ~w_rx_trig2;

`ifdef LATCH_REPORT_ACK_TIMEOUT_EN
  localparam int TOW = $clog2(pACK_TIMEOUT + 1);

  logic [TOW-1:0] r_to_cnt;

  // Zero outside WAIT_ACK, so it starts from zero on every entry.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      r_to_cnt <= '0;
    end else if ((r_state != ST_WAIT_ACK) || w_restart) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_restart = (r_state == ST_WAIT_ACK) & ~w_rx_ack &
                     (r_to_cnt == TOW'(pACK_TIMEOUT - 1));
`else
  logic w_unused_timeout;

  assign w_restart        = 1'b0;
  assign w_unused_timeout = (pACK_TIMEOUT != 0);
`endif

  frame_serializer #(
    .pNBYTES (NB)
  ) u_ser (
    .iCLK     (iCLK),
    .iRSTn    (iRSTn),
    .iStart   (w_grant),
    .iRestart (w_restart),
    .iTag     (w_tag),
    .iData    (w_snap),
    .oTxData  (link.oTxData),
    .oTxValid (link.oTxValid),
    .iTxReady (link.iTxReady),
    .oDone    (w_done)
  );

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      r_state   <= ST_IDLE;
      r_rr_last <= 1'b1;  // ch2 "went last", so ch1 wins the first tie
      r_served  <= 1'b0;
      r_rst1    <= 1'b0;
      r_rst2    <= 1'b0;
      r_soft1   <= 1'b0;
      r_soft2   <= 1'b0;
      r_unexp   <= 8'h00;
    end else begin
      r_soft1 <= w_rx_trig1;
      r_soft2 <= w_rx_trig2;
      if (w_rx_unexp && (r_unexp != 8'hFF)) begin
        r_unexp <= r_unexp + 8'h01;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_served <= w_grant_ch2;
            r_state  <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_done) begin
            r_state <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (w_rx_ack) begin
            r_rst1  <= ~r_served;
            r_rst2  <= r_served;
            r_state <= ST_CLEAR;
          end else if (w_restart) begin
            r_state <= ST_SEND;
          end
        end
        ST_CLEAR: begin
          if (!w_served_rdy) begin
            r_rst1    <= 1'b0;
            r_rst2    <= 1'b0;
            r_rr_last <= r_served;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign oResetLatch1 = r_rst1;
  assign oResetLatch2 = r_rst2;
  assign oSoftLatch1  = r_soft1;
  assign oSoftLatch2  = r_soft2;
  assign oUnexpected  = r_unexp;
  assign oBusy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire
